mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module     : mem_arbiter
// Description: Three-port arbiter for a single-port memory macro. It grants
//              one port at a time, with a fixed priority and anti-starvation
//              promotion, and sequences the precharge, sense and drive phases.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [2:0]  sel0,
  input  logic [2:0]  sel1,
  input  logic [2:0]  sel2,
  input  logic [5:0]  addr0,
  input  logic [5:0]  addr1,
  input  logic [5:0]  addr2,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [15:0] wdata2,
  input  logic [15:0] mem_read_in,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        rd_valid,
  output logic        busy,
  output logic [5:0]  mem_address,
  output logic [2:0]  mem_sel,
  output logic [15:0] mem_data_out,
  output logic        PC_B,
  output logic        WE,
  output logic        SE,
  output logic [1:0]  RorW
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    SENSE = 3'd2,
    DRIVE = 3'd3,
    REL   = 3'd4
  } state_t;

  localparam logic [1:0] C_RW_IDLE  = 2'b00;
  localparam logic [1:0] C_RW_READ  = 2'b01;
  localparam logic [1:0] C_RW_WRITE = 2'b10;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_port, w_port_nxt;      // one-hot owner of the transaction
  logic        r_op_we, w_op_we_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic [1:0]  r_wait1, w_wait1_nxt;
  logic [1:0]  r_wait2, w_wait2_nxt;

  logic [2:0]  w_gnt_nxt, w_done_nxt, w_mem_sel_nxt;
  logic        w_err_nxt, w_rd_valid_nxt, w_busy_nxt;
  logic        w_pc_b_nxt, w_we_nxt, w_se_nxt;
  logic [1:0]  w_rorw_nxt;
  logic [5:0]  w_mem_addr_nxt;
  logic [15:0] w_mem_data_nxt, w_rdata_nxt;

  logic [2:0]  w_win;
  logic        w_win_we;
  logic [2:0]  w_win_sel;
  logic [5:0]  w_win_addr;
  logic [15:0] w_win_wdata;
  logic        w_sel_ok;

  // Winner selection: a starved port (counter saturated) outranks base priority
  always_comb begin
    w_win = 3'b000;
    if (req[1] && (r_wait1 == 2'd3))      w_win = 3'b010;
    else if (req[2] && (r_wait2 == 2'd3)) w_win = 3'b100;
    else if (req[0])                      w_win = 3'b001;
    else if (req[1])                      w_win = 3'b010;
    else if (req[2])                      w_win = 3'b100;

    w_win_we    = we[0];
    w_win_sel   = sel0;
    w_win_addr  = addr0;
    w_win_wdata = wdata0;
    case (w_win)
      3'b010: begin
        w_win_we = we[1]; w_win_sel = sel1; w_win_addr = addr1; w_win_wdata = wdata1;
      end
      3'b100: begin
        w_win_we = we[2]; w_win_sel = sel2; w_win_addr = addr2; w_win_wdata = wdata2;
      end
      default: ;
    endcase

    w_sel_ok = (w_win_sel == 3'b001) || (w_win_sel == 3'b010) || (w_win_sel == 3'b100);
  end

  // Next state and next registered outputs; pulses default low, data holds
  always_comb begin
    w_state_nxt    = r_state;
    w_port_nxt     = r_port;
    w_op_we_nxt    = r_op_we;
    w_wdata_nxt    = r_wdata;
    w_wait1_nxt    = r_wait1;
    w_wait2_nxt    = r_wait2;
    w_gnt_nxt      = 3'b000;
    w_done_nxt     = 3'b000;
    w_err_nxt      = 1'b0;
    w_rd_valid_nxt = 1'b0;
    w_pc_b_nxt     = 1'b1;
    w_we_nxt       = 1'b0;
    w_se_nxt       = 1'b0;
    w_rorw_nxt     = RorW;
    w_mem_sel_nxt  = mem_sel;
    w_mem_addr_nxt = mem_address;
    w_mem_data_nxt = mem_data_out;
    w_rdata_nxt    = rdata;

    case (r_state)
      IDLE: begin
        if (|req) begin
          w_gnt_nxt  = w_win;
          w_port_nxt = w_win;
          if (w_win[1])                         w_wait1_nxt = 2'd0;
          else if (req[1] && r_wait1 != 2'd3)   w_wait1_nxt = r_wait1 + 2'd1;
          if (w_win[2])                         w_wait2_nxt = 2'd0;
          else if (req[2] && r_wait2 != 2'd3)   w_wait2_nxt = r_wait2 + 2'd1;
          if (w_sel_ok) begin
            w_state_nxt    = PRE;
            w_op_we_nxt    = w_win_we;
            w_wdata_nxt    = w_win_wdata;
            w_pc_b_nxt     = 1'b0;
            w_mem_addr_nxt = w_win_addr;
            w_mem_sel_nxt  = w_win_sel;
            w_rorw_nxt     = w_win_we ? C_RW_WRITE : C_RW_READ;
          end else begin
            // Bad bank select: flag it and drop straight to release, no memory activity
            w_err_nxt   = 1'b1;
            w_state_nxt = REL;
          end
        end
      end
      PRE: begin
        if (r_op_we) begin
          w_state_nxt    = DRIVE;
          w_we_nxt       = 1'b1;
          w_mem_data_nxt = r_wdata;
        end else begin
          w_state_nxt = SENSE;
          w_se_nxt    = 1'b1;
        end
      end
      SENSE: begin
        w_state_nxt    = REL;
        w_rdata_nxt    = mem_read_in;
        w_rd_valid_nxt = 1'b1;
        w_done_nxt     = r_port;
      end
      DRIVE: begin
        w_state_nxt = REL;
        w_done_nxt  = r_port;
      end
      REL: begin
        w_state_nxt   = IDLE;
        w_rorw_nxt    = C_RW_IDLE;
        w_mem_sel_nxt = 3'b000;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State, transaction latches and all outputs update together on the clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_port       <= 3'b000;
      r_op_we      <= 1'b0;
      r_wdata      <= 16'h0000;
      r_wait1      <= 2'd0;
      r_wait2      <= 2'd0;
      gnt          <= 3'b000;
      done         <= 3'b000;
      err          <= 1'b0;
      rd_valid     <= 1'b0;
      busy         <= 1'b0;
      PC_B         <= 1'b1;
      WE           <= 1'b0;
      SE           <= 1'b0;
      RorW         <= C_RW_IDLE;
      mem_sel      <= 3'b000;
      mem_address  <= 6'd0;
      mem_data_out <= 16'h0000;
      rdata        <= 16'h0000;
    end else begin
      r_state      <= w_state_nxt;
      r_port       <= w_port_nxt;
      r_op_we      <= w_op_we_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wait1      <= w_wait1_nxt;
      r_wait2      <= w_wait2_nxt;
      gnt          <= w_gnt_nxt;
      done         <= w_done_nxt;
      err          <= w_err_nxt;
      rd_valid     <= w_rd_valid_nxt;
      busy         <= w_busy_nxt;
      PC_B         <= w_pc_b_nxt;
      WE           <= w_we_nxt;
      SE           <= w_se_nxt;
      RorW         <= w_rorw_nxt;
      mem_sel      <= w_mem_sel_nxt;
      mem_address  <= w_mem_addr_nxt;
      mem_data_out <= w_mem_data_nxt;
      rdata        <= w_rdata_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module     : tb_mem_arbiter
// Description: Directed self-checking bench for mem_arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req, we, sel0, sel1, sel2;
  logic [5:0]  addr0, addr1, addr2;
  logic [15:0] wdata0, wdata1, wdata2, mem_read_in;
  logic [2:0]  gnt, done, mem_sel;
  logic        err, rd_valid, busy, PC_B, WE, SE;
  logic [15:0] rdata, mem_data_out;
  logic [5:0]  mem_address;
  logic [1:0]  RorW;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .sel0(sel0), .sel1(sel1), .sel2(sel2),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .mem_read_in(mem_read_in),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .rd_valid(rd_valid),
    .busy(busy), .mem_address(mem_address), .mem_sel(mem_sel),
    .mem_data_out(mem_data_out), .PC_B(PC_B), .WE(WE), .SE(SE), .RorW(RorW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset values of every output
  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    total++; if (PC_B !== 1'b1 || WE !== 1'b0 || SE !== 1'b0) begin bad++; $display("FAIL rst_ctrl: PC_B=%b WE=%b SE=%b want 1 0 0", PC_B, WE, SE); end
    total++; if (RorW !== 2'b00 || mem_sel !== 3'b000 || mem_address !== 6'd0) begin bad++; $display("FAIL rst_mem: RorW=%b sel=%b addr=%0d want 00 000 0", RorW, mem_sel, mem_address); end
    total++; if (gnt !== 3'b000 || done !== 3'b000 || err !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL rst_flags: gnt=%b done=%b err=%b busy=%b rdv=%b want zeros", gnt, done, err, busy, rd_valid); end
    total++; if (rdata !== 16'h0 || mem_data_out !== 16'h0) begin bad++; $display("FAIL rst_data: rdata=%h mdo=%h want 0 0", rdata, mem_data_out); end
    reset = 1'b0;
  endtask

  // Port2 read; inputs change after grant and must be ignored
  task automatic test_read;
    req = 3'b100; we = 3'b000; sel2 = 3'b001; addr2 = 6'd5; mem_read_in = 16'hA5C3;
    @(negedge clk);
    total++; if (gnt !== 3'b100) begin bad++; $display("FAIL rd_gnt: got %b want 100", gnt); end
    total++; if (PC_B !== 1'b0 || mem_address !== 6'd5 || RorW !== 2'b01 || mem_sel !== 3'b001 || SE !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rd_pre: PC_B=%b addr=%0d RorW=%b sel=%b SE=%b busy=%b want 0 5 01 001 0 1", PC_B, mem_address, RorW, mem_sel, SE, busy); end
    req = 3'b000; addr2 = 6'd9;
    @(negedge clk);
    total++; if (SE !== 1'b1 || PC_B !== 1'b1 || WE !== 1'b0 || gnt !== 3'b000) begin bad++; $display("FAIL rd_sense: SE=%b PC_B=%b WE=%b gnt=%b want 1 1 0 000", SE, PC_B, WE, gnt); end
    mem_read_in = 16'hA5C3;
    @(negedge clk);
    total++; if (rdata !== 16'hA5C3 || rd_valid !== 1'b1 || done !== 3'b100 || SE !== 1'b0) begin bad++; $display("FAIL rd_rel: rdata=%h rdv=%b done=%b SE=%b want a5c3 1 100 0", rdata, rd_valid, done, SE); end
    mem_read_in = 16'h0000;
    @(negedge clk);
    total++; if (busy !== 1'b0 || RorW !== 2'b00 || mem_sel !== 3'b000 || mem_address !== 6'd5 || rdata !== 16'hA5C3 || done !== 3'b000 || rd_valid !== 1'b0) begin bad++; $display("FAIL rd_idle: busy=%b RorW=%b sel=%b addr=%0d rdata=%h done=%b rdv=%b want 0 00 000 5 a5c3 000 0", busy, RorW, mem_sel, mem_address, rdata, done, rd_valid); end
  endtask

  // Port0 write; wdata changes after latch and must be ignored
  task automatic test_write;
    req = 3'b001; we = 3'b001; sel0 = 3'b010; addr0 = 6'd3; wdata0 = 16'h1234;
    @(negedge clk);
    total++; if (gnt !== 3'b001 || PC_B !== 1'b0 || RorW !== 2'b10 || mem_address !== 6'd3 || WE !== 1'b0) begin bad++; $display("FAIL wr_pre: gnt=%b PC_B=%b RorW=%b addr=%0d WE=%b want 001 0 10 3 0", gnt, PC_B, RorW, mem_address, WE); end
    req = 3'b000; wdata0 = 16'hFFFF;
    @(negedge clk);
    total++; if (WE !== 1'b1 || mem_data_out !== 16'h1234 || SE !== 1'b0 || PC_B !== 1'b1) begin bad++; $display("FAIL wr_drive: WE=%b mdo=%h SE=%b PC_B=%b want 1 1234 0 1", WE, mem_data_out, SE, PC_B); end
    @(negedge clk);
    total++; if (done !== 3'b001 || WE !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL wr_rel: done=%b WE=%b rdv=%b want 001 0 0", done, WE, rd_valid); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || mem_data_out !== 16'h1234 || done !== 3'b000) begin bad++; $display("FAIL wr_idle: busy=%b mdo=%h done=%b want 0 1234 000", busy, mem_data_out, done); end
  endtask

  // All ports request continuously; starved ports get promoted
  task automatic test_fairness;
    logic [2:0] seq [5];
    logic [2:0] exp_seq [5];
    int         cyc [5];
    int         n;
    exp_seq = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100};
    n = 0;
    req = 3'b111; we = 3'b000; sel0 = 3'b001; sel1 = 3'b010; sel2 = 3'b100;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (gnt !== 3'b000) begin seq[n] = gnt; cyc[n] = c; n++; end
    end
    req = 3'b000;
    total++; if (n != 5) begin bad++; $display("FAIL fair_count: got %0d grants want 5", n); end
    for (int k = 0; k < n; k++) begin
      total++; if (seq[k] !== exp_seq[k]) begin bad++; $display("FAIL fair_gnt%0d: got %b want %b", k, seq[k], exp_seq[k]); end
    end
    if (n >= 2) begin
      total++; if (cyc[1] - cyc[0] != 4) begin bad++; $display("FAIL fair_period: got %0d cycles want 4", cyc[1] - cyc[0]); end
    end
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fair_idle: busy=%b want 0", busy); end
  endtask

  // Non-one-hot select: grant with error, no memory activity
  task automatic test_err;
    req = 3'b010; we = 3'b000; sel1 = 3'b011; addr1 = 6'd12;
    @(negedge clk);
    total++; if (gnt !== 3'b010 || err !== 1'b1) begin bad++; $display("FAIL err_pulse: gnt=%b err=%b want 010 1", gnt, err); end
    total++; if (PC_B !== 1'b1 || WE !== 1'b0 || SE !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL err_ctrl: PC_B=%b WE=%b SE=%b busy=%b want 1 0 0 1", PC_B, WE, SE, busy); end
    req = 3'b000; sel1 = 3'b010;
    @(negedge clk);
    total++; if (busy !== 1'b0 || err !== 1'b0 || gnt !== 3'b000 || done !== 3'b000 || SE !== 1'b0 || WE !== 1'b0) begin bad++; $display("FAIL err_after: busy=%b err=%b gnt=%b done=%b SE=%b WE=%b want 0 0 000 000 0 0", busy, err, gnt, done, SE, WE); end
    @(negedge clk);
    total++; if (done !== 3'b000) begin bad++; $display("FAIL err_nodone: done=%b want 000", done); end
  endtask

  // Reset during DRIVE abandons the write; a fresh port1 write follows
  task automatic test_reset_mid;
    req = 3'b010; we = 3'b010; sel1 = 3'b100; addr1 = 6'd7; wdata1 = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    total++; if (WE !== 1'b1) begin bad++; $display("FAIL rm_drive: WE=%b want 1", WE); end
    #2 reset = 1'b1;
    #1;
    total++; if (WE !== 1'b0 || PC_B !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rm_async: WE=%b PC_B=%b busy=%b want 0 1 0", WE, PC_B, busy); end
    @(negedge clk);
    total++; if (done !== 3'b000) begin bad++; $display("FAIL rm_nodone1: done=%b want 000", done); end
    @(negedge clk);
    total++; if (done !== 3'b000 || gnt !== 3'b000) begin bad++; $display("FAIL rm_nodone2: done=%b gnt=%b want 000 000", done, gnt); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (gnt !== 3'b010 || RorW !== 2'b10 || mem_address !== 6'd7 || mem_sel !== 3'b100) begin bad++; $display("FAIL rm_regnt: gnt=%b RorW=%b addr=%0d sel=%b want 010 10 7 100", gnt, RorW, mem_address, mem_sel); end
    req = 3'b000;
    @(negedge clk);
    total++; if (WE !== 1'b1 || mem_data_out !== 16'hBEEF) begin bad++; $display("FAIL rm_drive2: WE=%b mdo=%h want 1 beef", WE, mem_data_out); end
    @(negedge clk);
    total++; if (done !== 3'b010) begin bad++; $display("FAIL rm_done: done=%b want 010", done); end
    @(negedge clk);
  endtask

  // Request held through done is granted again at the next IDLE edge
  task automatic test_back_to_back;
    logic [2:0] exp_g [5];
    exp_g = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b001};
    @(negedge clk);
    req = 3'b001; we = 3'b000; sel0 = 3'b010; addr0 = 6'd33;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (gnt !== exp_g[c]) begin bad++; $display("FAIL b2b_gnt%0d: got %b want %b", c, gnt, exp_g[c]); end
      if (c == 2) begin
        total++; if (done !== 3'b001) begin bad++; $display("FAIL b2b_done: got %b want 001", done); end
      end
    end
    req = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    req = 3'b000; we = 3'b000;
    sel0 = 3'b001; sel1 = 3'b001; sel2 = 3'b001;
    addr0 = 6'd0; addr1 = 6'd0; addr2 = 6'd0;
    wdata0 = 16'h0; wdata1 = 16'h0; wdata2 = 16'h0;
    mem_read_in = 16'h0;
    reset = 1'b1;
    test_reset();
    test_read();
    test_write();
    test_fairness();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
